// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: classifies the instruction, builds the sign-extended immediate
// and execute controls, and holds the decoded bundle in a valid/ready pipeline register.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      type_out,
    output logic [3:0]      alu_op,
    output logic [2:0]      funct3,
    output logic [8:0]      ctrl,
    output logic            illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_SB  = 3'd3;
    localparam logic [2:0] T_UJ  = 3'd4;
    localparam logic [2:0] T_U   = 3'd5;
    localparam logic [2:0] T_ILL = 3'd7;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ctrl = {reg_write,mem_read,mem_write,branch,jal,jalr,alu_src_imm,pc_src_a,md_en}
    localparam logic [8:0] C_RW   = 9'h100;
    localparam logic [8:0] C_MR   = 9'h080;
    localparam logic [8:0] C_MW   = 9'h040;
    localparam logic [8:0] C_BR   = 9'h020;
    localparam logic [8:0] C_JAL  = 9'h010;
    localparam logic [8:0] C_JALR = 9'h008;
    localparam logic [8:0] C_IMM  = 9'h004;
    localparam logic [8:0] C_PCA  = 9'h002;
    localparam logic [8:0] C_MD   = 9'h001;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [31:0]     imm32;
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_rd;
    logic [3:0]      alu_base;
    logic [2:0]      raw_type;
    logic [3:0]      raw_alu;
    logic [8:0]      raw_ctrl;

    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic [3:0]      dec_alu;
    logic [8:0]      dec_ctrl;
    logic            dec_ill;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    always_comb begin
        case (f3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    end

    always_comb begin
        imm32    = 32'h0;
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        raw_type = T_ILL;
        raw_alu  = ALU_ADD;
        raw_ctrl = 9'h0;
        case (opcode)
            OPC_OP: begin
                raw_type = T_R;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                use_rd   = 1'b1;
                raw_ctrl = C_RW;
                if (f7 == 7'h00) begin
                    legal   = 1'b1;
                    raw_alu = alu_base;
                end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal   = 1'b1;
                    raw_alu = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else if (f7 == 7'h01 && ENABLE_M) begin
                    // M-extension sub-op travels on funct3; the ALU op stays ADD
                    legal    = 1'b1;
                    raw_ctrl = C_RW | C_MD;
                end
            end
            OPC_OP_IMM: begin
                raw_type = T_I;
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                imm32    = {{20{inst[31]}}, inst[31:20]};
                raw_ctrl = C_RW | C_IMM;
                raw_alu  = alu_base;
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) raw_alu = ALU_SRA;
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_LOAD: begin
                raw_type = T_I;
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                imm32    = {{20{inst[31]}}, inst[31:20]};
                raw_ctrl = C_RW | C_MR | C_IMM;
                legal    = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_JALR: begin
                raw_type = T_I;
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                imm32    = {{20{inst[31]}}, inst[31:20]};
                raw_ctrl = C_RW | C_JALR | C_IMM;
                legal    = (f3 == 3'b000);
            end
            OPC_STORE: begin
                raw_type = T_S;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                raw_ctrl = C_MW | C_IMM;
                legal    = (f3 <= 3'b010);
            end
            OPC_BRANCH: begin
                raw_type = T_SB;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                imm32    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                raw_alu  = ALU_SUB;
                raw_ctrl = C_BR;
                legal    = !(f3 == 3'b010 || f3 == 3'b011);
            end
            OPC_JAL: begin
                raw_type = T_UJ;
                use_rd   = 1'b1;
                imm32    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                raw_ctrl = C_RW | C_JAL | C_IMM | C_PCA;
                legal    = 1'b1;
            end
            OPC_LUI: begin
                raw_type = T_U;
                use_rd   = 1'b1;
                imm32    = {inst[31:12], 12'h000};
                raw_alu  = ALU_PASSB;
                raw_ctrl = C_RW | C_IMM;
                legal    = 1'b1;
            end
            OPC_AUIPC: begin
                raw_type = T_U;
                use_rd   = 1'b1;
                imm32    = {inst[31:12], 12'h000};
                raw_ctrl = C_RW | C_IMM | C_PCA;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (inst[1:0] != 2'b11) legal = 1'b0;
    end

    // An illegal word carries no operands or controls, only the trap flag
    always_comb begin
        dec_ill  = !legal;
        dec_rs1  = (legal && use_rs1) ? inst[19:15] : 5'd0;
        dec_rs2  = (legal && use_rs2) ? inst[24:20] : 5'd0;
        dec_rd   = (legal && use_rd)  ? inst[11:7]  : 5'd0;
        dec_imm  = legal ? XLEN'($signed(imm32)) : '0;
        dec_type = legal ? raw_type : T_ILL;
        dec_alu  = legal ? raw_alu  : ALU_ADD;
        dec_ctrl = legal ? raw_ctrl : 9'h0;
    end

    logic            out_valid_q, out_valid_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [2:0]      type_q, type_d, funct3_q, funct3_d;
    logic [3:0]      alu_q, alu_d;
    logic [8:0]      ctrl_q, ctrl_d;
    logic            illegal_q, illegal_d;
    logic            accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Data registers load on any accept; flush only has to suppress the valid bit
    always_comb begin
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;
        out_pc_d  = accept ? pc       : out_pc_q;
        rs1_d     = accept ? dec_rs1  : rs1_q;
        rs2_d     = accept ? dec_rs2  : rs2_q;
        rd_d      = accept ? dec_rd   : rd_q;
        imm_d     = accept ? dec_imm  : imm_q;
        type_d    = accept ? dec_type : type_q;
        alu_d     = accept ? dec_alu  : alu_q;
        funct3_d  = accept ? f3       : funct3_q;
        ctrl_d    = accept ? dec_ctrl : ctrl_q;
        illegal_d = accept ? dec_ill  : illegal_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            type_q      <= '0;
            alu_q       <= '0;
            funct3_q    <= '0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            type_q      <= type_d;
            alu_q       <= alu_d;
            funct3_q    <= funct3_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign imm       = imm_q;
    assign type_out  = type_q;
    assign alu_op    = alu_q;
    assign funct3    = funct3_q;
    assign ctrl      = ctrl_q;
    assign illegal   = illegal_q;

endmodule
